branch_hazard_ctrl: RTL and testbench
=====================================

# branch_hazard_ctrl

Pipeline sequencer for the DLX branch-in-ID scheme. Branches resolve in the decode stage from the `PC_sel` decision, so their compare operands must be final in ID. This block detects data hazards on branch and load-use operands and holds the front end for a counted number of cycles. It then flushes IF/ID when a resolved branch is taken, and keeps saturating event counters for performance readout. It sits in instruction_decode, beside the branch decision logic, and drives the PC, IF/ID and ID/EX register controls.

## Interface
- `CNT_W`, 16, width of the saturating event counters
- `REG_W`, 5, register index width
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `id_branch`  in  1  the instruction in ID is a conditional branch (`DE_control[1]`)
- `id_rs`, `id_rt`  in  REG_W  source registers of the ID instruction
- `id_uses_rt`  in  1  the ID instruction reads rt
- `pc_sel`  in  1  branch-taken decision from branch logic; valid only when `id_branch`=1
- `ex_reg_write`, `ex_mem_read`  in  1  control bits of the instruction in EX
- `ex_rd`  in  REG_W  destination of the instruction in EX
- `mem_mem_read`  in  1  the instruction in MEM is a load
- `mem_rd`  in  REG_W  destination of the instruction in MEM
- `hold`  in  1  external freeze (memory wait)
- `pc_write`  out  1  PC register enable
- `ifid_write`  out  1  IF/ID register enable
- `ifid_flush`  out  1  IF/ID register loads a NOP
- `idex_bubble`  out  1  ID/EX register loads a NOP
- `stalled`  out  1  the block is in state STALL
- `taken_cnt`, `stall_cnt`  out  CNT_W  saturating counts of taken branches and stall cycles

## Operation
- States: RUN and STALL. A 2-bit down-counter `rem` holds the number of stall cycles still owed.
- A match condition (`matchX`) requires X_rd != 0 and either X_rd == `id_rs` or (`id_uses_rt` and X_rd == `id_rt`).
- Stall need is evaluated only in RUN, as a priority chain:
  - `id_branch`, `ex_mem_read` and `matchEX`: need 2.
  - `id_branch`, `ex_reg_write` and `matchEX`: need 1.
  - `id_branch`, `mem_mem_read` and `matchMEM`: need 1.
  - `ex_mem_read` and `matchEX` (load-use, non-branch): need 1.
  - Otherwise: need 0.
- RUN with need > 0:
  - Outputs this cycle: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
  - Next state: if need = 1, stay in RUN; if need = 2, go to STALL with `rem` = 1.
- STALL:
  - Inputs are ignored and the same stall outputs are driven.
  - `rem` decrements each cycle; when `rem` = 0 after the decrement, go to RUN.
  - RUN then re-evaluates need.
- RUN with need = 0 and `id_branch` and `pc_sel`:
  - `ifid_flush`=1 and `pc_write`=1, so the PC loads the target.
  - `taken_cnt` increments.
- `pc_sel` is ignored whenever need > 0 or the state is STALL.
- `hold` has priority over everything else:
  - Outputs: `pc_write`=0, `ifid_write`=0, `idex_bubble`=0, `ifid_flush`=0.
  - State, `rem` and both counters are frozen.
  - A branch decision pending during `hold` is taken when `hold` is released.
- `stall_cnt` increments on every non-hold cycle with `idex_bubble`=1.
- Both counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- Hazard detection, `ifid_flush` and all enables are combinational from the current inputs and state, in the same cycle; only state, `rem` and the counters are registered.
- A load in EX feeding a branch produces 2 bubble cycles, N and N+1; the branch resolves in N+2.
- An ALU result in EX feeding a branch produces 1 bubble; the branch resolves in N+1 using the EX/MEM forward.
- Taken-branch penalty is exactly 1 flushed slot.
- Reset values and behaviour:
  - State RUN, `rem`=0, `taken_cnt`=`stall_cnt`=0.
  - While `rst`=1, outputs are forced to `pc_write`=0, `ifid_write`=0, `ifid_flush`=0, `idex_bubble`=1, `stalled`=0.
  - `rst` asserted during STALL abandons the stall; the first cycle after reset is RUN.
- `hold` and a hazard in the same cycle: `hold` wins and the hazard is re-evaluated next cycle.

## Structure
- Shared package `dlx_pipe_pkg` holds:
  - the state encoding (RUN=0, STALL=1);
  - the stall-need constants `STALL_LOAD_BR`=2, `STALL_ALU_BR`=1, `STALL_LOAD_USE`=1;
  - the `REG_W` default.
- One combinational sub-module, `branch_hazard_detect`, computes need from the register and control inputs.
- The FSM, counter and output mux live in the top module.

## Test plan
- Branch, EX=`lw r3` (`ex_mem_read`=1, `ex_rd`=3), `id_rs`=3 -> `idex_bubble`=1 in cycles 0 and 1, `stalled`=1 in cycle 1, branch resolves in cycle 2, `stall_cnt`=2.
- Branch, EX=`add r4` (`ex_reg_write`=1, `ex_rd`=4), `id_rt`=4, `id_uses_rt`=1 -> exactly 1 bubble; `pc_sel`=1 in cycle 1 gives `ifid_flush`=1, `taken_cnt`=1.
- Branch with `ex_rd`=0 matching `id_rs`=0 -> no stall; `pc_sel`=0 gives no flush.
- `hold`=1 raised in the STALL cycle for 3 cycles -> all enables 0, `rem` and counters frozen; after release exactly 1 more bubble cycle.
- `rst` asserted during STALL -> forced reset outputs; the next cycle is RUN, counters are 0, and the inputs are re-evaluated.
- `CNT_W`=2 with 5 taken branches -> `taken_cnt` holds at 3.

Source files
------------

// File: rtl/dlx_pipe_pkg.sv
// Shared DLX pipeline definitions: sequencer state encoding, stall-need
// constants and the default register index width.
package dlx_pipe_pkg;

  localparam int REG_W_DFLT = 5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;

  localparam logic [1:0] STALL_NONE     = 2'd0;
  localparam logic [1:0] STALL_LOAD_BR  = 2'd2;
  localparam logic [1:0] STALL_ALU_BR   = 2'd1;
  localparam logic [1:0] STALL_LOAD_USE = 2'd1;

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational stall-need evaluation for branch-in-ID operands and
// load-use dependencies against the EX and MEM destinations.
module branch_hazard_detect
  import dlx_pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DFLT
) (
  input  logic             id_branch,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  output logic [1:0]       need
);

  logic match_ex;
  logic match_mem;

  // r0 is hardwired zero, so it can never carry a real dependency
  assign match_ex  = (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign match_mem = (mem_rd != '0) &&
                     ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

  always_comb begin
    need = STALL_NONE;
    if (id_branch && ex_mem_read && match_ex)
      need = STALL_LOAD_BR;
    else if (id_branch && ex_reg_write && match_ex)
      need = STALL_ALU_BR;
    else if (id_branch && mem_mem_read && match_mem)
      need = STALL_ALU_BR;
    else if (ex_mem_read && match_ex)
      need = STALL_LOAD_USE;
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Front-end sequencer for the branch-in-ID pipeline: counted stalls on
// operand hazards, taken-branch flush and saturating event counters.
module branch_hazard_ctrl
  import dlx_pipe_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = REG_W_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_branch,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             pc_sel,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             hold,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             stalled,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  hz_state_e        state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [1:0]       need;
  logic [CNT_W-1:0] taken_cnt_q, stall_cnt_q;

  branch_hazard_detect #(.REG_W(REG_W)) u_detect (
    .id_branch    (id_branch),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .mem_mem_read (mem_mem_read),
    .mem_rd       (mem_rd),
    .need         (need)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      rem_q       <= 2'd0;
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (ifid_flush && (taken_cnt_q != '1))
        taken_cnt_q <= taken_cnt_q + 1'b1;
      if (idex_bubble && !hold && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (!hold) begin
      case (state_q)
        ST_RUN: begin
          // the first bubble of a load-to-branch stall is spent in RUN
          if (need == STALL_LOAD_BR) begin
            state_d = ST_STALL;
            rem_d   = 2'd1;
          end
        end
        ST_STALL: begin
          rem_d = rem_q - 2'd1;
          if (rem_d == 2'd0)
            state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      idex_bubble = 1'b1;
    end else if (hold) begin
      idex_bubble = 1'b0;
    end else if ((state_q == ST_STALL) || (need != STALL_NONE)) begin
      idex_bubble = 1'b1;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = id_branch & pc_sel;
    end
  end

  assign stalled   = !rst && (state_q == ST_STALL);
  assign taken_cnt = taken_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: hazard stalls, flush, hold,
// reset during stall and counter saturation on a narrow instance.
module tb_branch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_branch, id_uses_rt, pc_sel;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       ex_reg_write, ex_mem_read, mem_mem_read, hold;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, stalled;
  logic [15:0] taken_cnt, stall_cnt;

  logic       br2, sel2;
  logic       pc_write2, ifid_write2, ifid_flush2, idex_bubble2, stalled2;
  logic [1:0] taken_cnt2, stall_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.CNT_W(16), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .id_branch(id_branch), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .pc_sel(pc_sel), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_mem_read(mem_mem_read),
    .mem_rd(mem_rd), .hold(hold), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .stalled(stalled),
    .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );

  branch_hazard_ctrl #(.CNT_W(2), .REG_W(5)) dut_sat (
    .clk(clk), .rst(rst), .id_branch(br2), .id_rs(5'd0), .id_rt(5'd0),
    .id_uses_rt(1'b0), .pc_sel(sel2), .ex_reg_write(1'b0),
    .ex_mem_read(1'b0), .ex_rd(5'd0), .mem_mem_read(1'b0),
    .mem_rd(5'd0), .hold(1'b0), .pc_write(pc_write2), .ifid_write(ifid_write2),
    .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2), .stalled(stalled2),
    .taken_cnt(taken_cnt2), .stall_cnt(stall_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_branch = 0; id_uses_rt = 0; pc_sel = 0; id_rs = 0; id_rt = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0;
    mem_mem_read = 0; mem_rd = 0; hold = 0;
  endtask

  // advance to the next falling edge; inputs set afterwards are seen by the next rising edge
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load_branch_hazard();
    idle();
    id_branch = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd3; id_rs = 5'd3;
  endtask

  initial begin
    idle();
    br2 = 0; sel2 = 0;
    rst = 1;

    // reset
    cyc(); #1;
    check("rst_pc_write", pc_write, 0);
    check("rst_ifid_write", ifid_write, 0);
    check("rst_flush", ifid_flush, 0);
    check("rst_bubble", idex_bubble, 1);
    check("rst_stalled", stalled, 0);
    cyc(); #1;
    check("rst_taken", taken_cnt, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    rst = 0; #1;
    check("idle_pc_write", pc_write, 1);
    check("idle_bubble", idex_bubble, 0);

    // load in EX feeding a branch: bubbles in cycles 0 and 1
    cyc(); load_branch_hazard(); #1;
    check("lbr_c0_bubble", idex_bubble, 1);
    check("lbr_c0_pc_write", pc_write, 0);
    check("lbr_c0_stalled", stalled, 0);
    cyc(); pc_sel = 1; #1;
    check("lbr_c1_bubble", idex_bubble, 1);
    check("lbr_c1_stalled", stalled, 1);
    check("lbr_c1_flush", ifid_flush, 0);
    cyc(); idle(); id_branch = 1; id_rs = 5'd3; #1;
    check("lbr_c2_bubble", idex_bubble, 0);
    check("lbr_c2_pc_write", pc_write, 1);
    check("lbr_c2_stalled", stalled, 0);
    check("lbr_stall_cnt", stall_cnt, 2);

    // ALU result in EX feeding a branch via rt: one bubble, then taken
    cyc(); idle();
    id_branch = 1; ex_reg_write = 1; ex_rd = 5'd4; id_rt = 5'd4; id_uses_rt = 1;
    id_rs = 5'd7; pc_sel = 1; #1;
    check("alu_c0_bubble", idex_bubble, 1);
    check("alu_c0_flush", ifid_flush, 0);
    cyc(); ex_reg_write = 0; ex_rd = 0; mem_rd = 5'd4; #1;
    check("alu_c1_bubble", idex_bubble, 0);
    check("alu_c1_flush", ifid_flush, 1);
    check("alu_c1_pc_write", pc_write, 1);
    check("alu_stall_cnt", stall_cnt, 3);
    cyc(); idle(); #1;
    check("alu_taken", taken_cnt, 1);

    // r0 never matches; not-taken branch gives no flush
    cyc(); id_branch = 1; ex_reg_write = 1; ex_mem_read = 1; ex_rd = 0; id_rs = 0; #1;
    check("r0_bubble", idex_bubble, 0);
    check("r0_flush", ifid_flush, 0);
    check("r0_pc_write", pc_write, 1);

    // load in MEM feeding a branch: one bubble, stays in RUN
    cyc(); idle(); id_branch = 1; mem_mem_read = 1; mem_rd = 5'd5; id_rs = 5'd5; #1;
    check("memld_bubble", idex_bubble, 1);
    cyc(); idle(); #1;
    check("memld_stalled", stalled, 0);

    // plain load-use on rt, then the same with rt unused
    cyc(); ex_mem_read = 1; ex_rd = 5'd6; id_rt = 5'd6; id_uses_rt = 1; #1;
    check("lu_bubble", idex_bubble, 1);
    cyc(); id_uses_rt = 0; #1;
    check("lu_nort_bubble", idex_bubble, 0);
    check("lu_stall_cnt", stall_cnt, 5);

    // hold raised in the STALL cycle for three cycles
    cyc(); load_branch_hazard(); #1;
    check("hold_c0_bubble", idex_bubble, 1);
    cyc(); idle(); hold = 1; id_branch = 1; pc_sel = 1; #1;
    check("hold_pc_write", pc_write, 0);
    check("hold_ifid_write", ifid_write, 0);
    check("hold_bubble", idex_bubble, 0);
    check("hold_flush", ifid_flush, 0);
    check("hold_stalled", stalled, 1);
    cyc(); #1;
    check("hold2_stalled", stalled, 1);
    cyc(); #1;
    check("hold3_stalled", stalled, 1);
    check("hold_stall_cnt", stall_cnt, 6);
    cyc(); hold = 0; #1;
    check("rel_bubble", idex_bubble, 1);
    check("rel_stalled", stalled, 1);
    check("rel_flush", ifid_flush, 0);
    cyc(); #1;
    check("rel2_stalled", stalled, 0);
    check("rel2_flush", ifid_flush, 1);
    check("rel2_stall_cnt", stall_cnt, 7);
    cyc(); idle(); #1;
    check("rel_taken", taken_cnt, 2);

    // reset asserted in the STALL cycle
    cyc(); load_branch_hazard(); #1;
    check("rs_c0_bubble", idex_bubble, 1);
    cyc(); rst = 1; #1;
    check("rs_stalled", stalled, 0);
    check("rs_bubble", idex_bubble, 1);
    check("rs_pc_write", pc_write, 0);
    cyc(); rst = 0; idle(); id_branch = 1; ex_reg_write = 1; ex_rd = 5'd4; id_rs = 5'd4; #1;
    check("rs_after_stalled", stalled, 0);
    check("rs_after_bubble", idex_bubble, 1);
    check("rs_after_stall_cnt", stall_cnt, 0);
    check("rs_after_taken", taken_cnt, 0);
    cyc(); idle(); #1;
    check("rs_after2_stall_cnt", stall_cnt, 1);

    // narrow counters saturate at 3 after five taken branches
    cyc(); br2 = 1; sel2 = 1; #1;
    check("sat_flush", ifid_flush2, 1);
    repeat (5) cyc();
    #1;
    check("sat_taken", taken_cnt2, 3);
    check("sat_stall_cnt", stall_cnt2, 0);
    br2 = 0; sel2 = 0;
    cyc(); #1;
    check("sat_hold_value", taken_cnt2, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
